// File: rtl/julia_pkg.sv
// julia_pkg: widths, frame geometry, FSM encoding and escape limit
// shared by the Julia-set pixel generator and its datapath.
package julia_pkg;

    localparam int W           = 18;
    localparam int FRAC        = 13;
    localparam int X_PX        = 800;
    localparam int Y_PX        = 480;
    localparam int FRAME_WORDS = X_PX * Y_PX;
    localparam int MAX_ITER    = 63;
    localparam int X_START     = -12288;
    localparam int Y_START     = -7373;
    localparam int STEP        = 31;

    localparam int AW = 22;
    localparam int DW = 32;
    localparam int IW = 8;

    typedef logic signed [W-1:0] fix_t;

    // |z|^2 escape bound: 4.0 in Q(2*FRAC), held at full product width
    localparam logic signed [2*W:0] ESCAPE_LIMIT =
        {{(2*W-2*FRAC-2){1'b0}}, 1'b1, {(2*FRAC+2){1'b0}}};

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_PAL  = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    // Palette entry for an escape count (cap handled by the caller)
    function automatic logic [23:0] palette_rgb(input logic [IW-1:0] i);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = i << 2;
        g = 8'hff - r;
        b = {i[3:0], i[7:4]};
        return {r, g, b};
    endfunction

endpackage

// File: rtl/julia_pixel_gen_if.sv
// julia_pixel_gen_if: valid/ready pixel word channel towards
// the SDRAM write sequencer.
interface julia_pixel_gen_if;
    import julia_pkg::*;

    logic          pix_valid;
    logic          pix_ready;
    logic [AW-1:0] pix_addr;
    logic [DW-1:0] pix_data;

    modport master (
        output pix_valid,
        output pix_addr,
        output pix_data,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_addr,
        input  pix_data,
        output pix_ready
    );

endinterface

// File: rtl/julia_iter.sv
// julia_iter: one combinational z <- z^2 + c step plus the escape
// test on |z|^2, taken at full width before any shift.
module julia_iter
    import julia_pkg::*;
(
    input  fix_t zr,
    input  fix_t zi,
    input  fix_t c_re,
    input  fix_t c_im,
    output fix_t zr_nx,
    output fix_t zi_nx,
    output logic escape
);

    logic signed [2*W-1:0] rr;
    logic signed [2*W-1:0] ii;
    logic signed [2*W-1:0] ri;
    logic signed [2*W:0]   mag;
    logic signed [2*W:0]   diff;
    logic signed [2*W:0]   twice;

    // Squares, cross term, escape compare and wrapped next z
    always_comb begin
        rr     = (2*W)'(zr) * (2*W)'(zr);
        ii     = (2*W)'(zi) * (2*W)'(zi);
        ri     = (2*W)'(zr) * (2*W)'(zi);
        mag    = (2*W+1)'(rr) + (2*W+1)'(ii);
        diff   = (2*W+1)'(rr) - (2*W+1)'(ii);
        twice  = {ri, 1'b0};
        escape = mag > ESCAPE_LIMIT;
        zr_nx  = fix_t'(diff >>> FRAC) + c_re;
        zi_nx  = fix_t'(twice >>> FRAC) + c_im;
    end

endmodule

// File: rtl/julia_pixel_gen.sv
// julia_pixel_gen: raster-order Julia-set renderer feeding SDRAM writes.
// JULIA_PALETTE_EN: registered 256x24 palette instead of grey ramp.
module julia_pixel_gen #(
    parameter int X_PX     = julia_pkg::X_PX,
    parameter int Y_PX     = julia_pkg::Y_PX,
    parameter int MAX_ITER = julia_pkg::MAX_ITER,
    parameter int X_START  = julia_pkg::X_START,
    parameter int Y_START  = julia_pkg::Y_START,
    parameter int STEP     = julia_pkg::STEP
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  julia_pkg::fix_t           c_re,
    input  julia_pkg::fix_t           c_im,
    output logic                      busy,
    output logic                      frame_done,
    julia_pixel_gen_if.master         pix
);
    import julia_pkg::*;

    localparam logic [15:0]   X_LAST   = 16'(X_PX - 1);
    localparam logic [15:0]   Y_LAST   = 16'(Y_PX - 1);
    localparam fix_t          X0       = fix_t'(X_START);
    localparam fix_t          Y0       = fix_t'(Y_START);
    localparam fix_t          STEP_W   = fix_t'(STEP);
    localparam logic [IW-1:0] ITER_CAP = IW'(MAX_ITER);

    logic [2:0]    state;
    logic [15:0]   x;
    logic [15:0]   y;
    logic [AW-1:0] addr;
    logic [IW-1:0] iter;
    fix_t          zr;
    fix_t          zi;
    fix_t          zr0;
    fix_t          zi0;
    fix_t          cr;
    fix_t          ci;
    fix_t          zr_nx;
    fix_t          zi_nx;
    logic          mag_esc;
    logic          esc;
    logic          xfer;
    logic [23:0]   rgb;

    julia_iter u_iter (
        .zr     (zr),
        .zi     (zi),
        .c_re   (cr),
        .c_im   (ci),
        .zr_nx  (zr_nx),
        .zi_nx  (zi_nx),
        .escape (mag_esc)
    );

    assign esc  = mag_esc || (iter == ITER_CAP);
    assign xfer = (state == S_OUT) && pix.pix_ready;

`ifdef JULIA_PALETTE_EN
    localparam logic [2:0] S_ESC = S_PAL;
    logic [23:0] pal_q;

    // Palette ROM read, registered during the cycle after escape
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pal_q <= '0;
        end else if (state == S_PAL) begin
            pal_q <= (iter == ITER_CAP) ? 24'd0 : palette_rgb(iter);
        end
    end

    assign rgb = pal_q;
`else
    localparam logic [2:0] S_ESC = S_OUT;
    logic [7:0] grey;

    assign grey = (iter == ITER_CAP) ? 8'd0 : 8'(iter << 2);
    assign rgb  = {grey, grey, grey};
`endif

    // Frame FSM: pixel counters, plane origin and iteration state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            x     <= '0;
            y     <= '0;
            addr  <= '0;
            iter  <= '0;
            zr    <= '0;
            zi    <= '0;
            zr0   <= '0;
            zi0   <= '0;
            cr    <= '0;
            ci    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cr    <= c_re;
                        ci    <= c_im;
                        x     <= '0;
                        y     <= '0;
                        addr  <= '0;
                        zr0   <= X0;
                        zi0   <= Y0;
                        busy  <= 1'b1;
                        state <= S_INIT;
                    end
                end
                S_INIT: begin
                    zr    <= zr0;
                    zi    <= zi0;
                    iter  <= '0;
                    state <= S_ITER;
                end
                S_ITER: begin
                    if (esc) begin
                        state <= S_ESC;
                    end else begin
                        zr   <= zr_nx;
                        zi   <= zi_nx;
                        iter <= iter + IW'(1);
                    end
                end
                S_PAL: begin
                    state <= S_OUT;
                end
                S_OUT: begin
                    if (xfer) begin
                        addr <= addr + AW'(1);
                        if (x == X_LAST) begin
                            x   <= '0;
                            y   <= y + 16'd1;
                            zr0 <= X0;
                            zi0 <= zi0 + STEP_W;
                        end else begin
                            x   <= x + 16'd1;
                            zr0 <= zr0 + STEP_W;
                        end
                        if (x == X_LAST && y == Y_LAST) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_INIT;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign frame_done    = (state == S_DONE);
    assign pix.pix_valid = (state == S_OUT);
    assign pix.pix_addr  = addr;
    assign pix.pix_data  = {8'd0, rgb};

endmodule

// File: tb/tb_julia_pixel_gen.sv
// tb_julia_pixel_gen: directed checks on four small-frame instances
// of julia_pixel_gen (grey build).
module tb_julia_pixel_gen;
    import julia_pkg::*;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b0;
    logic [3:0]       start   = '0;
    logic [3:0]       rdy     = '0;
    logic [3:0][W-1:0] cre    = '0;
    logic [3:0][W-1:0] cim    = '0;
    wire  [3:0]       v;
    wire  [3:0]       busy;
    wire  [3:0]       fdone;
    wire  [3:0][21:0] a;
    wire  [3:0][31:0] d;
    int               n_run  = 0;
    int               n_fail = 0;

    always #5 clk = ~clk;

    // 0: 1x1 at origin, 1: 1x1 at 3.0, 2: 1x1 at 1.0, 3: 16x8 default corner
    for (genvar g = 0; g < 4; g++) begin : gen_dut
        julia_pixel_gen_if pif ();
        assign pif.pix_ready = rdy[g];
        assign v[g] = pif.pix_valid;
        assign a[g] = pif.pix_addr;
        assign d[g] = pif.pix_data;
        julia_pixel_gen #(
            .X_PX    (g == 3 ? 16 : 1),
            .Y_PX    (g == 3 ? 8 : 1),
            .MAX_ITER(63),
            .X_START (g == 1 ? 24576 : g == 2 ? 8192 : g == 3 ? -12288 : 0),
            .Y_START (g == 3 ? -7373 : 0),
            .STEP    (31)
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .start     (start[g]),
            .c_re      (cre[g]),
            .c_im      (cim[g]),
            .busy      (busy[g]),
            .frame_done(fdone[g]),
            .pix       (pif)
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fire(input int i);
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
    endtask

    task automatic wait_valid(input int i, input int lim, output int cyc);
        cyc = 0;
        while (!v[i] && cyc < lim) begin
            tick();
            cyc++;
        end
        check($sformatf("valid_to%0d", i), {63'd0, v[i]}, 64'd1);
    endtask

    task automatic run_frame(input int i, input int lim, output int nx,
                             output int bad, output int nfd,
                             output logic [31:0] d_first);
        nx      = 0;
        bad     = 0;
        nfd     = 0;
        d_first = '0;
        for (int k = 0; k < lim && nfd == 0; k++) begin
            rdy[i] = 1'($urandom_range(0, 1));
            if (v[i] && rdy[i]) begin
                if (a[i] != 22'(nx)) bad++;
                if (nx == 0) d_first = d[i];
                nx++;
            end
            if (fdone[i]) nfd++;
            tick();
        end
    endtask

    initial begin
        int          lat;
        int          nx;
        int          bad;
        int          nfd;
        int          t;
        int          extra;
        logic [31:0] df;

        repeat (3) tick();
        for (int i = 0; i < 4; i++)
            check($sformatf("rst_out%0d", i),
                  {busy[i], fdone[i], v[i], a[i], d[i]}, 64'd0);
        reset_n = 1'b1;
        tick();

        // 1: z stays 0, runs to the cap -> black, 66 cycles
        rdy[0] = 1'b1;
        fire(0);
        check("t1_busy", busy[0], 1);
        wait_valid(0, 200, lat);
        check("t1_lat", lat + 1, 66);
        check("t1_addr", a[0], 0);
        check("t1_data", d[0], 0);
        tick();
        check("t1_done", {v[0], fdone[0], busy[0]}, 3'b011);
        tick();
        check("t1_idle", {fdone[0], busy[0]}, 0);

        // 2: z0 = 3.0 escapes at iteration 0
        rdy[1] = 1'b1;
        fire(1);
        wait_valid(1, 50, lat);
        check("t2_lat", lat + 1, 3);
        check("t2_pix", {a[1], d[1]}, 0);
        tick();
        check("t2_done", {v[1], fdone[1]}, 2'b01);

        // 3: z0 = 1.0, c = 1.0: |z|^2 == 4.0 exactly at z = 2 keeps going
        cre[2] = 18'd8192;
        rdy[2] = 1'b1;
        fire(2);
        wait_valid(2, 50, lat);
        check("t3_lat", lat + 1, 5);
        check("t3_data", d[2], 32'h0008_0808);
        tick();
        check("t3_done", {v[2], fdone[2]}, 2'b01);
        tick();

        // 4: stall 20 cycles, then exactly one transfer
        rdy[2] = 1'b0;
        fire(2);
        wait_valid(2, 50, lat);
        for (int k = 0; k < 20; k++) begin
            tick();
            check($sformatf("t4_hold%0d", k),
                  {fdone[2], v[2], a[2], d[2]},
                  {1'b0, 1'b1, 22'd0, 32'h0008_0808});
        end
        rdy[2] = 1'b1;
        tick();
        rdy[2] = 1'b0;
        check("t4_xfer", {v[2], fdone[2]}, 2'b01);
        tick();
        check("t4_idle", {v[2], fdone[2], busy[2]}, 0);

        // 5: 16x8 frame under random ready
        rdy[3] = 1'b0;
        fire(3);
        run_frame(3, 20000, nx, bad, nfd, df);
        check("t5_fdone", nfd, 1);
        check("t5_count", nx, 128);
        check("t5_order", bad, 0);
        check("t5_pix0", df, 32'h0004_0404);
        check("t5_busy", busy[3], 0);
        extra = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (fdone[3]) extra++;
        end
        check("t5_one_done", extra, 0);

        // 6: reset mid-frame, restart from 0, start ignored while busy
        rdy[3] = 1'b1;
        fire(3);
        t = 0;
        while (a[3] != 22'd50 && t < 2000) begin
            tick();
            t++;
        end
        check("t6_mid", a[3], 50);
        reset_n = 1'b0;
        #1;
        check("t6_rst", {v[3], busy[3], fdone[3], a[3]}, 0);
        tick();
        reset_n = 1'b1;
        tick();
        rdy[3] = 1'b0;
        fire(3);
        wait_valid(3, 50, lat);
        check("t6_first", {busy[3], a[3], d[3]},
              {1'b1, 22'd0, 32'h0004_0404});
        start[3] = 1'b1;
        tick();
        start[3] = 1'b0;
        check("t6_ign", {busy[3], v[3], a[3]}, {1'b1, 1'b1, 22'd0});
        run_frame(3, 20000, nx, bad, nfd, df);
        check("t6_fdone", nfd, 1);
        check("t6_count", nx, 128);
        check("t6_order", bad, 0);
        tick();
        tick();
        check("t6_idle", {busy[3], v[3]}, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
